// File: rtl/sobel_gradient_if.sv
// Pixel-stream bundle between the window generator, the Sobel gradient stage
// and the image writer.
//   input_window      : 3x3 window, p_rc at [(3r+c)*PX_SIZE +: PX_SIZE]
//   input_data_valid  : window valid this cycle
//   output_data       : gradient pixel
//   output_data_valid : output_data valid this cycle
// master = stimulus side (drives the window), slave = gradient stage.
interface sobel_gradient_if #(
  parameter int unsigned PX_SIZE = 8
);
  logic [9*PX_SIZE-1:0] input_window;
  logic                 input_data_valid;
  logic [PX_SIZE-1:0]   output_data;
  logic                 output_data_valid;

  modport master (
    output input_window,
    output input_data_valid,
    input  output_data,
    input  output_data_valid
  );

  modport slave (
    input  input_window,
    input  input_data_valid,
    output output_data,
    output output_data_valid
  );
endinterface

// File: rtl/sobel_gradient.sv
// Three-stage Sobel gradient-magnitude pipeline: |Gx| + |Gy| saturated to
// pixel width, border pixels forced to zero, optional binarisation.
// Ports:
//   clk    : rising-edge clock
//   resetn : synchronous active-low reset
//   bus    : sobel_gradient_if slave (window in, gradient pixel out)
// Latency is three registers; one window per cycle, no backpressure.
module sobel_gradient #(
  parameter int unsigned PX_SIZE      = 8,
  parameter int unsigned IMAGE_WIDTH  = 64,
  parameter int unsigned IMAGE_HEIGHT = 64,
  parameter int unsigned THRESHOLD    = 0
) (
  input  logic            clk,
  input  logic            resetn,
  sobel_gradient_if.slave bus
);

  localparam int unsigned SUM_W = PX_SIZE + 2;
  localparam int unsigned DIF_W = PX_SIZE + 3;
  localparam int unsigned COL_W = $clog2(IMAGE_WIDTH);
  localparam int unsigned ROW_W = $clog2(IMAGE_HEIGHT);
  localparam logic [COL_W-1:0]   COL_LAST = COL_W'(IMAGE_WIDTH - 1);
  localparam logic [ROW_W-1:0]   ROW_LAST = ROW_W'(IMAGE_HEIGHT - 1);
  localparam logic [PX_SIZE-1:0] PX_MAX   = '1;

  logic [PX_SIZE-1:0] p [9];
  logic               unused_centre;

  // Window unpack; index 3r+c
  always_comb begin
    for (int i = 0; i < 9; i++) begin
      p[i] = bus.input_window[i*PX_SIZE +: PX_SIZE];
    end
  end

  // The centre pixel carries zero weight in both kernels
  assign unused_centre = ^p[4];

  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic             border;

  assign border = (col == '0) || (col == COL_LAST) ||
                  (row == '0) || (row == ROW_LAST);

  // Stage 1: positive/negative kernel halves
  logic [SUM_W-1:0] xp_c, xn_c, yp_c, yn_c;
  logic [SUM_W-1:0] xp1, xn1, yp1, yn1;
  logic             b1, v1;

  always_comb begin
    xp_c = SUM_W'(p[2]) + (SUM_W'(p[5]) << 1) + SUM_W'(p[8]);
    xn_c = SUM_W'(p[0]) + (SUM_W'(p[3]) << 1) + SUM_W'(p[6]);
    yp_c = SUM_W'(p[6]) + (SUM_W'(p[7]) << 1) + SUM_W'(p[8]);
    yn_c = SUM_W'(p[0]) + (SUM_W'(p[1]) << 1) + SUM_W'(p[2]);
  end

  // Stage 2: signed differences folded to magnitudes
  logic signed [DIF_W-1:0] gx_c, gy_c;
  logic        [SUM_W-1:0] ax_c, ay_c;
  logic        [SUM_W-1:0] ax2, ay2;
  logic                    b2, v2;

  always_comb begin
    gx_c = signed'(DIF_W'(xp1)) - signed'(DIF_W'(xn1));
    gy_c = signed'(DIF_W'(yp1)) - signed'(DIF_W'(yn1));
    ax_c = gx_c[DIF_W-1] ? SUM_W'(-gx_c) : SUM_W'(gx_c);
    ay_c = gy_c[DIF_W-1] ? SUM_W'(-gy_c) : SUM_W'(gy_c);
  end

  // Stage 3: sum, saturate, border mask, optional binarise
  logic [DIF_W-1:0]   mag_c;
  logic [PX_SIZE-1:0] sat_c;
  logic [PX_SIZE-1:0] pix_c;
  logic [PX_SIZE-1:0] out_data;
  logic               out_valid;

  always_comb begin
    mag_c = DIF_W'(ax2) + DIF_W'(ay2);
    sat_c = (mag_c > DIF_W'(PX_MAX)) ? PX_MAX : mag_c[PX_SIZE-1:0];
    pix_c = '0;
    if (b2) begin
      pix_c = '0;
    end else if (THRESHOLD == 0) begin
      pix_c = sat_c;
    end else begin
      pix_c = (32'(sat_c) >= THRESHOLD) ? PX_MAX : '0;
    end
  end

  // Control: valid shift, position counters, output register
  always_ff @(posedge clk) begin
    if (!resetn) begin
      v1        <= 1'b0;
      v2        <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      col       <= '0;
      row       <= '0;
    end else begin
      v1        <= bus.input_data_valid;
      v2        <= v1;
      out_valid <= v2;
      if (v2) begin
        out_data <= pix_c;
      end
      if (bus.input_data_valid) begin
        if (col == COL_LAST) begin
          col <= '0;
          row <= (row == ROW_LAST) ? '0 : row + ROW_W'(1);
        end else begin
          col <= col + COL_W'(1);
        end
      end
    end
  end

  // Datapath registers; only loaded when their stage holds a live window
  always_ff @(posedge clk) begin
    if (bus.input_data_valid) begin
      xp1 <= xp_c;
      xn1 <= xn_c;
      yp1 <= yp_c;
      yn1 <= yn_c;
      b1  <= border;
    end
    if (v1) begin
      ax2 <= ax_c;
      ay2 <= ay_c;
      b2  <= b1;
    end
  end

  assign bus.output_data       = out_data;
  assign bus.output_data_valid = out_valid;

endmodule

// File: tb/tb_sobel_gradient.sv
// Bench for sobel_gradient: two instances (magnitude and THRESHOLD=50) share
// one stimulus stream; a scoreboard queue holds expected pixels with the
// cycle they are due, fed from a vector table or a convolution model.
module tb_sobel_gradient;

  localparam int unsigned PX    = 8;
  localparam int unsigned W     = 64;
  localparam int unsigned H     = 64;
  localparam int unsigned THR   = 50;
  localparam int unsigned WIN_W = 9 * PX;
  localparam int          PXMAX = (1 << PX) - 1;

  typedef logic [WIN_W-1:0] win_t;
  typedef struct { int due; int e0; int e1; string tag; } exp_t;
  typedef struct { string name; win_t win; int e0; int e1; } vec_t;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   mrow = 0;
  int   mcol = 0;
  exp_t q[$];
  vec_t tab[11];
  bit   pat[6];
  win_t vstep;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sobel_gradient_if #(.PX_SIZE(PX)) bus0 ();
  sobel_gradient_if #(.PX_SIZE(PX)) bus1 ();

  sobel_gradient #(.PX_SIZE(PX), .IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .THRESHOLD(0)) dut0 (
    .clk(clk), .resetn(resetn), .bus(bus0));
  sobel_gradient #(.PX_SIZE(PX), .IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .THRESHOLD(THR)) dut1 (
    .clk(clk), .resetn(resetn), .bus(bus1));

  // Reference: direct 3x3 convolution with the Sobel kernels
  function automatic int model(win_t w, int r, int c, int thr);
    int kx[9];
    int ky[9];
    int gx, gy, px, mag;
    kx = '{-1, 0, 1, -2, 0, 2, -1, 0, 1};
    ky = '{-1, -2, -1, 0, 0, 0, 1, 2, 1};
    gx = 0;
    gy = 0;
    for (int i = 0; i < 9; i++) begin
      px = int'(w[i*PX +: PX]);
      gx += kx[i] * px;
      gy += ky[i] * px;
    end
    mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
    if (mag > PXMAX) mag = PXMAX;
    if (r == 0 || r == int'(H) - 1 || c == 0 || c == int'(W) - 1) return 0;
    if (thr == 0) return mag;
    return (mag >= thr) ? PXMAX : 0;
  endfunction

  function automatic win_t from_cols(int a, int b, int c);
    win_t w;
    int v[3];
    v = '{a, b, c};
    for (int r = 0; r < 3; r++)
      for (int k = 0; k < 3; k++)
        w[(3*r + k)*PX +: PX] = PX'(v[k]);
    return w;
  endfunction

  function automatic win_t from_rows(int a, int b, int c);
    win_t w;
    int v[3];
    v = '{a, b, c};
    for (int r = 0; r < 3; r++)
      for (int k = 0; k < 3; k++)
        w[(3*r + k)*PX +: PX] = PX'(v[r]);
    return w;
  endfunction

  function automatic win_t one_px(int idx, int val);
    win_t w;
    w = '0;
    w[idx*PX +: PX] = PX'(val);
    return w;
  endfunction

  function automatic win_t rand_win();
    win_t w;
    for (int i = 0; i < 9; i++) w[i*PX +: PX] = PX'($urandom_range(0, PXMAX));
    return w;
  endfunction

  task automatic chk(string name, int act, int expv);
    checks++;
    if (act != expv) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d cycle=%0d", name, act, expv, cyc);
    end
  endtask

  // Called once per cycle at the falling edge
  task automatic monitor();
    exp_t e;
    while (q.size() > 0 && q[0].due < cyc) begin
      checks++;
      failures++;
      $display("FAIL missing_output %s due=%0d now=%0d", q[0].tag, q[0].due, cyc);
      void'(q.pop_front());
    end
    if (bus0.output_data_valid === 1'b1 || bus1.output_data_valid === 1'b1) begin
      if (q.size() == 0 || q[0].due != cyc) begin
        checks++;
        failures++;
        $display("FAIL spurious_valid actual=%b/%b expected=0 cycle=%0d",
                 bus0.output_data_valid, bus1.output_data_valid, cyc);
      end else begin
        e = q.pop_front();
        chk({e.tag, "_valid0"}, int'(bus0.output_data_valid), 1);
        chk({e.tag, "_valid1"}, int'(bus1.output_data_valid), 1);
        chk({e.tag, "_mag"},    int'(bus0.output_data), e.e0);
        chk({e.tag, "_thr"},    int'(bus1.output_data), e.e1);
      end
    end
  endtask

  task automatic set_inputs(bit v, win_t w);
    bus0.input_data_valid = v;
    bus0.input_window     = w;
    bus1.input_data_valid = v;
    bus1.input_window     = w;
  endtask

  task automatic drive(bit v, win_t w, bit use_model, int e0, int e1, string tag);
    exp_t e;
    @(negedge clk);
    monitor();
    set_inputs(v, w);
    if (v) begin
      if (use_model) begin
        e0 = model(w, mrow, mcol, 0);
        e1 = model(w, mrow, mcol, int'(THR));
      end
      e.due = cyc + 3;
      e.e0  = e0;
      e.e1  = e1;
      e.tag = tag;
      q.push_back(e);
      if (mcol == int'(W) - 1) begin
        mcol = 0;
        mrow = (mrow == int'(H) - 1) ? 0 : mrow + 1;
      end else begin
        mcol++;
      end
    end
  endtask

  // One-cycle reset with a valid window presented (must be ignored)
  task automatic do_reset();
    @(negedge clk);
    monitor();
    resetn = 1'b0;
    set_inputs(1'b1, vstep);
    q.delete();
    mrow = 0;
    mcol = 0;
    @(negedge clk);
    chk("reset_valid0", int'(bus0.output_data_valid), 0);
    chk("reset_valid1", int'(bus1.output_data_valid), 0);
    chk("reset_data0",  int'(bus0.output_data), 0);
    chk("reset_data1",  int'(bus1.output_data), 0);
    resetn = 1'b1;
    set_inputs(1'b0, '0);
  endtask

  initial begin
    vstep   = from_cols(0, 128, 255);
    tab[0]  = '{"uniform",   from_cols(100, 100, 100), 0,   0};
    tab[1]  = '{"vstep",     vstep,                    255, 255};
    tab[2]  = '{"ramp",      from_cols(10, 20, 30),    80,  255};
    tab[3]  = '{"tramp",     from_rows(10, 20, 30),    80,  255};
    tab[4]  = '{"ramp40",    from_cols(10, 15, 20),    40,  0};
    tab[5]  = '{"negramp",   from_cols(30, 20, 10),    80,  255};
    tab[6]  = '{"thr_eq",    one_px(5, 25),            50,  255};
    tab[7]  = '{"thr_below", one_px(5, 24),            48,  0};
    tab[8]  = '{"sat_below", one_px(5, 127),           254, 255};
    tab[9]  = '{"sat_edge",  one_px(5, 128),           255, 255};
    tab[10] = '{"diag",      one_px(8, 100),           200, 255};
    pat     = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    set_inputs(1'b0, '0);

    do_reset();

    // Fill row 0 and (1,0) with random windows: all border, all zero
    repeat (W + 1) drive(1'b1, rand_win(), 1'b1, 0, 0, "border_fill");

    // Table vectors at interior positions (1,1)..(1,11)
    for (int i = 0; i < 11; i++) drive(1'b1, tab[i].win, 1'b0, tab[i].e0, tab[i].e1, tab[i].name);

    // Valid gap pattern
    for (int i = 0; i < 6; i++) drive(pat[i], rand_win(), 1'b1, 0, 0, "gap");
    repeat (4) drive(1'b0, '0, 1'b1, 0, 0, "idle");

    // Random windows with random gaps across several lines
    for (int i = 0; i < 600; i++) drive($urandom_range(0, 3) != 0, rand_win(), 1'b1, 0, 0, "random");

    // Full frame of step windows back-to-back, running into the next frame
    do_reset();
    repeat (W * H + W + 6) drive(1'b1, vstep, 1'b1, 0, 0, "frame");

    // Reset with two windows in flight
    drive(1'b1, vstep, 1'b1, 0, 0, "inflight");
    drive(1'b1, vstep, 1'b1, 0, 0, "inflight");
    do_reset();
    repeat (5) drive(1'b0, '0, 1'b1, 0, 0, "idle");
    drive(1'b1, vstep, 1'b0, 0, 0, "post_reset_origin");
    drive(1'b1, vstep, 1'b0, 0, 0, "post_reset_col1");

    repeat (6) drive(1'b0, '0, 1'b1, 0, 0, "drain");
    chk("queue_drained", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sobel_gradient.md
# sobel_gradient

Pipelined Sobel gradient-magnitude stage placed directly downstream of the sliding-window generator in the Sobel datapath. Consumes one 3x3 pixel window per valid cycle, computes |Gx| + |Gy|, saturates to pixel width, forces image-border pixels to zero and optionally binarises against a threshold. The output is a raster-ordered pixel stream, one output per accepted window, consumed by the image writer.

## Interface
- PX_SIZE, 8, pixel width in bits
- IMAGE_WIDTH, 64, pixels per line (≥ 3)
- IMAGE_HEIGHT, 64, lines per frame (≥ 3)
- THRESHOLD, 0, 0 = output magnitude; otherwise binarise (see Operation)

- clk  in  1  single clock; all logic on rising edge
- resetn  in  1  reset, synchronous, active-low
- input_window  in  9*PX_SIZE  3x3 window, p_rc at bits [(3r+c)*PX_SIZE +: PX_SIZE]; r=0 top row, c=0 left column; p11 = centre pixel
- input_data_valid  in  1  window valid this cycle
- output_data  out  PX_SIZE  gradient pixel
- output_data_valid  out  1  output_data valid this cycle

## Operation
- No backpressure: every window with input_data_valid=1 is accepted and yields exactly one output.
- Position counters col (0..IMAGE_WIDTH-1), row (0..IMAGE_HEIGHT-1) track the centre pixel; advance on each accepted window. col wraps to 0 at IMAGE_WIDTH-1 and increments row; row wraps to 0 at IMAGE_HEIGHT-1 (next frame starts, no gap needed).
- border = (col==0) | (col==IMAGE_WIDTH-1) | (row==0) | (row==IMAGE_HEIGHT-1), sampled with the window, carried down the pipeline.
- Stage 1 (register): unsigned sums, width PX_SIZE+2:
  - xp = p02 + 2·p12 + p22, xn = p00 + 2·p10 + p20
  - yp = p20 + 2·p21 + p22, yn = p00 + 2·p01 + p02
- Stage 2 (register): gx = xp − xn, gy = yp − yn as signed PX_SIZE+3; store |gx|, |gy| as unsigned PX_SIZE+2 (max 4·(2^PX_SIZE−1), no overflow).
- Stage 3 (register): mag = |gx| + |gy|, unsigned PX_SIZE+3; sat = min(mag, 2^PX_SIZE−1).
  - border → output_data = 0
  - else THRESHOLD==0 → output_data = sat
  - else → output_data = (sat ≥ THRESHOLD) ? 2^PX_SIZE−1 : 0
- Valid bit shifts through a 3-deep valid pipeline alongside data; data registers of invalid stages may hold stale values but output_data is only meaningful when output_data_valid=1.

## Timing
- Latency: window presented at edge N (input_data_valid=1) → output_data_valid=1 after edge N+3.
- Throughput: one window per cycle; input gaps appear as identical gaps at output, delayed by 3 cycles, order preserved.
- Reset (resetn=0 at a rising edge): output_data=0, output_data_valid=0, all stage valid bits 0, col=0, row=0. Windows in flight are discarded; no output emitted for them.
- Input sampled in the same cycle resetn=0 is ignored.
- First window after reset release is treated as (row 0, col 0).
- Mid-frame reset: counters restart at (0,0); upstream is responsible for restarting the frame.
- Line/frame wrap and border flag take effect on the window that carries the wrapping position; no dead cycle at wrap.

## Test plan
- Uniform window: all nine pixels = 100, centre at interior position (row 1, col 1) → output_data=0, valid exactly 3 cycles after input.
- Vertical step: left column 0, middle 128, right column 255, interior → gx=1020, gy=0, saturates → output_data=255.
- Linear ramp: columns 10/20/30 (rows identical), interior → gx=80, gy=0 → output_data=80; transposed ramp (rows 10/20/30) → 80.
- Full 64x64 frame of vertical-step windows streamed back-to-back → 4096 outputs; all of row 0, row 63, col 0, col 63 = 0, interior = 255; second frame starts again with border at (0,0).
- Valid gaps: pattern 1,0,0,1,1,0 on input_data_valid → identical pattern on output_data_valid shifted by 3 cycles; counters advance only on valid cycles.
- THRESHOLD=50: interior ramp with gx=40 → 0; gx=80 → 255. Reset asserted with 2 windows in flight → no output_data_valid afterwards, output_data=0, next window treated as (0,0) border → 0.
